// File: rtl/down_counter_timer_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
package down_counter_timer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter with one-shot or periodic (auto-reload) operation.
// Terminal count is flagged by a registered one-cycle done pulse.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             load_accept;

  assign load_ready  = (state_q == IDLE) & ~abort;
  assign load_accept = load_valid & load_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load_accept) begin
      count_d  = load_value;
      reload_d = load_value;
      mode_d   = auto_reload;
      // A zero load expires immediately without ever entering RUN.
      if (load_value != '0) begin
        state_d = RUN;
      end else begin
        done_d = 1'b1;
      end
    end else if ((state_q == RUN) && enable) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (mode_q) begin
        count_d = reload_q;
        done_d  = 1'b1;
      end else begin
        count_d = '0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  assign q    = count_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer.
module tb_down_counter_timer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] load_value = '0;
  logic             auto_reload = 1'b0;
  logic             enable = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_pass   = 0;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .enable     (enable),
    .abort      (abort),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int exp_q, input int exp_busy,
                           input int exp_done);
    chk({tag, "_q"}, 32'(q), 32'(exp_q));
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
  endtask

  task automatic do_load(input int value, input logic mode);
    load_valid  = 1'b1;
    load_value  = WIDTH'(value);
    auto_reload = mode;
    step();
    load_valid  = 1'b0;
  endtask

  initial begin
    int exp_q;
    int early_done;
    int q_err;

    // Reset state
    #1;
    chk_state("reset", 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("ready_after_reset", 32'(load_ready), 32'd1);

    // One-shot load of 5
    enable = 1'b1;
    do_load(5, 1'b0);
    chk_state("os_load", 5, 1, 0);
    chk("os_ready_busy", 32'(load_ready), 32'd0);
    for (int i = 4; i >= 1; i--) begin
      step();
      chk_state($sformatf("os_cnt%0d", i), i, 1, 0);
    end
    step();
    chk_state("os_expire", 0, 0, 1);
    chk("os_ready_back", 32'(load_ready), 32'd1);
    step();
    chk_state("os_after", 0, 0, 0);

    // Periodic load of 3 for 10 enabled cycles
    do_load(3, 1'b1);
    chk_state("per_load", 3, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      exp_q = 3 - ((i + 1) % 3);
      chk_state($sformatf("per_c%0d", i), exp_q, 1, (exp_q == 3) ? 1 : 0);
    end

    // Abort at q=2 together with a load request
    abort      = 1'b1;
    load_valid = 1'b1;
    load_value = 8'd7;
    #1;
    chk("abort_ready", 32'(load_ready), 32'd0);
    step();
    chk_state("abort", 0, 0, 0);
    abort      = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("abort_ready_back", 32'(load_ready), 32'd1);
    step();
    chk_state("abort_after", 0, 0, 0);

    // Pause at q=2, with a rejected load of 9 during RUN
    do_load(4, 1'b0);
    chk_state("pz_load", 4, 1, 0);
    step();
    step();
    chk_state("pz_q2", 2, 1, 0);
    enable     = 1'b0;
    load_valid = 1'b1;
    load_value = 8'd9;
    #1;
    chk("pz_busy_ready", 32'(load_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state($sformatf("pz_hold%0d", i), 2, 1, 0);
    end
    load_valid = 1'b0;
    enable     = 1'b1;
    step();
    chk_state("pz_q1", 1, 1, 0);
    step();
    chk_state("pz_expire", 0, 0, 1);

    // Load of zero: immediate done, never busy
    do_load(0, 1'b0);
    chk_state("zero_load", 0, 0, 1);
    step();
    chk_state("zero_after", 0, 0, 0);

    // Periodic reload of 1: done every enabled cycle
    do_load(1, 1'b1);
    chk_state("p1_load", 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_state($sformatf("p1_c%0d", i), 1, 1, 1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_state("p1_abort", 0, 0, 0);

    // Max one-shot load of 255
    do_load(255, 1'b0);
    chk_state("m255_load", 255, 1, 0);
    early_done = 0;
    q_err      = 0;
    for (int i = 1; i < 255; i++) begin
      step();
      if (done !== 1'b0) early_done++;
      if (q !== WIDTH'(255 - i)) q_err++;
    end
    chk("m255_early_done", 32'(early_done), 32'd0);
    chk("m255_q_track", 32'(q_err), 32'd0);
    step();
    chk_state("m255_expire", 0, 0, 1);

    // Async reset between edges while counting
    do_load(5, 1'b0);
    step();
    chk_state("ar_pre", 4, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_state("ar_immediate", 0, 0, 0);
    #1;
    reset = 1'b0;
    step();
    chk_state("ar_after", 0, 0, 0);
    chk("ar_ready", 32'(load_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
